// File: rtl/duck_line_prefetch_if.sv
// Shared sprite ROM port: the prefetcher drives the address, the ROM returns
// the palette index for that address one cycle later.
interface duck_line_prefetch_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/duck_line_prefetch.sv
// Duck sprite line prefetcher: time-shares one sprite ROM port to build line N+1
// into a double-buffered line buffer while line N is read out pixel by pixel.
module duck_line_prefetch #(
    parameter int unsigned NUM_DUCKS = 3,
    parameter int unsigned SPRITE_W  = 50,
    parameter int unsigned SPRITE_H  = 50,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    line_start,
    input  logic [9:0]              next_y,
    input  logic [NUM_DUCKS*10-1:0] duck_x,
    input  logic [NUM_DUCKS*10-1:0] duck_y,
    input  logic [NUM_DUCKS-1:0]    duck_en,
    duck_line_prefetch_if.master    rom,
    input  logic [9:0]              pix_rd_x,
    output logic [3:0]              pix_index,
    output logic                    busy,
    output logic                    overrun
);
    localparam int unsigned X_W   = 10;
    localparam int unsigned WX_W  = X_W + 1;
    localparam int unsigned COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DUCKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CHECK,
        S_FETCH,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state;
    logic             rd_bank;
    logic             line_valid;
    logic [X_W-1:0]   row_y;
    logic [X_W-1:0]   clr_x;
    logic [X_W-1:0]   x0;
    logic [IDX_W-1:0] duck_i;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    // a_*: address presented to the ROM this cycle; d_*: its data is on rom_data now
    logic             a_v;
    logic             d_v;
    logic [WX_W-1:0]  a_wx;
    logic [WX_W-1:0]  d_wx;

    logic [3:0]       bank0 [H_ACTIVE];
    logic [3:0]       bank1 [H_ACTIVE];

    logic [X_W-1:0]   sel_x_c;
    logic [X_W-1:0]   sel_y_c;
    logic             sel_en_c;
    logic [WX_W-1:0]  y_lo_c;
    logic [WX_W-1:0]  y_hi_c;
    logic [WX_W-1:0]  row_y_c;
    logic             hit_c;

    logic             wr_en_c;
    logic [X_W-1:0]   wr_addr_c;
    logic [3:0]       wr_data_c;

    logic             rd_in_range_c;
    logic [X_W-1:0]   rd_idx_c;
    logic [3:0]       rd_word_c;

    // Current duck's position/enable and row hit test (11-bit, no wrap)
    always_comb begin
        sel_x_c  = '0;
        sel_y_c  = '0;
        sel_en_c = 1'b0;
        for (int k = 0; k < NUM_DUCKS; k++) begin
            if (duck_i == IDX_W'(k)) begin
                sel_x_c  = duck_x[k*X_W +: X_W];
                sel_y_c  = duck_y[k*X_W +: X_W];
                sel_en_c = duck_en[k];
            end
        end
        y_lo_c  = {1'b0, sel_y_c};
        y_hi_c  = y_lo_c + WX_W'(SPRITE_H - 1);
        row_y_c = {1'b0, row_y};
        hit_c   = sel_en_c && (row_y_c >= y_lo_c) && (row_y_c <= y_hi_c);
    end

    // Single write port into the fill bank: clearing, or an opaque on-screen sprite pixel
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        if (Reset_n && !line_start) begin
            if (state == S_CLEAR) begin
                wr_en_c   = 1'b1;
                wr_addr_c = clr_x;
            end else if (d_v && (rom.rom_data != 4'd0) && (d_wx < WX_W'(H_ACTIVE))) begin
                wr_en_c   = 1'b1;
                wr_addr_c = d_wx[X_W-1:0];
                wr_data_c = rom.rom_data;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en_c) begin
            if (rd_bank) begin
                bank0[wr_addr_c] <= wr_data_c;
            end else begin
                bank1[wr_addr_c] <= wr_data_c;
            end
        end
    end

    always_comb begin
        rd_in_range_c = WX_W'(pix_rd_x) < WX_W'(H_ACTIVE);
        rd_idx_c      = rd_in_range_c ? pix_rd_x : '0;
        rd_word_c     = rd_bank ? bank1[rd_idx_c] : bank0[rd_idx_c];
    end

    // Fill scheduler, bank swap and registered read port
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            rd_bank      <= 1'b0;
            line_valid   <= 1'b0;
            row_y        <= '0;
            clr_x        <= '0;
            x0           <= '0;
            duck_i       <= '0;
            row          <= '0;
            col          <= '0;
            a_v          <= 1'b0;
            d_v          <= 1'b0;
            a_wx         <= '0;
            d_wx         <= '0;
            rom.rom_addr <= '0;
            pix_index    <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            a_v       <= 1'b0;
            d_v       <= a_v;
            d_wx      <= a_wx;
            pix_index <= (line_valid && rd_in_range_c) ? rd_word_c : 4'd0;

            if (line_start) begin
                // An unfinished fill is dropped; its bank is shown as-is
                rd_bank    <= ~rd_bank;
                line_valid <= 1'b1;
                row_y      <= next_y;
                clr_x      <= '0;
                busy       <= 1'b1;
                overrun    <= busy;
                d_v        <= 1'b0;
                state      <= S_CLEAR;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_CLEAR: begin
                        if (clr_x == X_W'(H_ACTIVE - 1)) begin
                            duck_i <= '0;
                            state  <= S_CHECK;
                        end else begin
                            clr_x <= clr_x + X_W'(1);
                        end
                    end
                    S_CHECK: begin
                        if (hit_c) begin
                            row   <= ROW_W'(row_y - sel_y_c);
                            x0    <= sel_x_c;
                            col   <= '0;
                            state <= S_FETCH;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                    S_FETCH: begin
                        rom.rom_addr <= ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
                        a_v          <= 1'b1;
                        a_wx         <= WX_W'(x0) + WX_W'(col);
                        if (col == COL_W'(SPRITE_W - 1)) begin
                            state <= S_DRAIN;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (duck_i == IDX_W'(NUM_DUCKS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            duck_i <= duck_i + IDX_W'(1);
                            state  <= S_CHECK;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_duck_line_prefetch.sv
// Directed + randomized bench for duck_line_prefetch against a per-pixel
// painter's-algorithm model of the finished scanline.
module tb_duck_line_prefetch;
    localparam int unsigned NUM_DUCKS = 3;
    localparam int unsigned SPRITE_W  = 50;
    localparam int unsigned SPRITE_H  = 50;
    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned ADDR_W    = 12;
    localparam int          FULL_FILL = H_ACTIVE + NUM_DUCKS * (SPRITE_W + 3) + 2;

    logic                    Clk = 1'b0;
    logic                    Reset_n;
    logic                    line_start;
    logic [9:0]              next_y;
    logic [NUM_DUCKS*10-1:0] duck_x;
    logic [NUM_DUCKS*10-1:0] duck_y;
    logic [NUM_DUCKS-1:0]    duck_en;
    logic [9:0]              pix_rd_x;
    logic [3:0]              pix_index;
    logic                    busy;
    logic                    overrun;

    duck_line_prefetch_if #(.ADDR_W(ADDR_W)) rom_bus ();

    duck_line_prefetch #(
        .NUM_DUCKS(NUM_DUCKS), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
        .H_ACTIVE(H_ACTIVE), .ADDR_W(ADDR_W)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .next_y(next_y),
        .duck_x(duck_x), .duck_y(duck_y), .duck_en(duck_en), .rom(rom_bus),
        .pix_rd_x(pix_rd_x), .pix_index(pix_index), .busy(busy), .overrun(overrun)
    );

    always #10 Clk = ~Clk;

    // Synchronous sprite ROM, one cycle of read latency
    logic [3:0] rom_mem [1 << ADDR_W];
    always @(posedge Clk) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];

    int         dx  [NUM_DUCKS];
    int         dy  [NUM_DUCKS];
    bit         den [NUM_DUCKS];
    logic [3:0] exp_line [H_ACTIVE];
    int         n_eval = 0;
    int         n_fail = 0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_eval++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic apply_cfg();
        for (int d = 0; d < NUM_DUCKS; d++) begin
            duck_x[d*10 +: 10] = 10'(dx[d]);
            duck_y[d*10 +: 10] = 10'(dy[d]);
            duck_en[d]         = den[d];
        end
    endtask

    function automatic bit duck_on_row(input int d, input int y);
        return den[d] && (y >= dy[d]) && (y < dy[d] + int'(SPRITE_H));
    endfunction

    // Paint ducks in ascending index; opaque pixels replace whatever is below
    function automatic void model_line(input int y);
        logic [3:0] w;
        for (int x = 0; x < int'(H_ACTIVE); x++) begin
            exp_line[x] = 4'd0;
            for (int d = 0; d < NUM_DUCKS; d++) begin
                if (duck_on_row(d, y) && x >= dx[d] && x < dx[d] + int'(SPRITE_W)) begin
                    w = rom_mem[(y - dy[d]) * int'(SPRITE_W) + (x - dx[d])];
                    if (w != 4'd0) exp_line[x] = w;
                end
            end
        end
    endfunction

    function automatic int model_cycles(input int y);
        int c;
        c = int'(H_ACTIVE) + 2;
        for (int d = 0; d < NUM_DUCKS; d++)
            c += duck_on_row(d, y) ? int'(SPRITE_W) + 3 : 2;
        return c;
    endfunction

    task automatic pulse_line(input int y, input bit exp_ovr);
        line_start = 1'b1;
        next_y     = 10'(y);
        step();
        line_start = 1'b0;
        chk("overrun_at_start", overrun, exp_ovr);
        chk("busy_at_start", busy, 1);
    endtask

    // Counts clock edges from the one sampling line_start to the one clearing busy
    task automatic wait_fill(input int exp_cyc, output int first_addr);
        int n;
        logic [ADDR_W-1:0] a0;
        n = 1;
        a0 = rom_bus.rom_addr;
        first_addr = -1;
        while (busy && n < 3000) begin
            step();
            n++;
            chk("overrun_quiet", overrun, 0);
            if (first_addr < 0 && rom_bus.rom_addr !== a0) first_addr = int'(rom_bus.rom_addr);
        end
        chk("fill_cycles", n, exp_cyc);
        chk("busy_done", busy, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic read_px(input int x, output logic [3:0] v);
        pix_rd_x = 10'(x);
        step();
        v = pix_index;
    endtask

    task automatic sweep(input string tag);
        logic [3:0] v;
        for (int x = 0; x < int'(H_ACTIVE); x++) begin
            read_px(x, v);
            chk(tag, v, exp_line[x]);
        end
        read_px(H_ACTIVE, v);
        chk("read_past_edge", v, 0);
        read_px(1023, v);
        chk("read_far_right", v, 0);
    endtask

    // Fill row y, then swap banks so that fill is displayed and compare it all
    task automatic do_line(input int y, input string tag, output int fa);
        wait_idle();
        pulse_line(y, 0);
        wait_fill(model_cycles(y), fa);
        model_line(y);
        pulse_line((y + 1) % 1024, 0);
        sweep(tag);
    endtask

    task automatic rom_random(input bit allow_zero);
        int r;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            r = $urandom_range(0, 3);
            rom_mem[a] = (allow_zero && r == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
    endtask

    initial begin
        int         fa;
        int         y;
        logic [3:0] v;

        Reset_n = 1'b0; line_start = 1'b0; next_y = '0; pix_rd_x = '0;
        for (int d = 0; d < NUM_DUCKS; d++) begin dx[d] = 0; dy[d] = 0; den[d] = 0; end
        apply_cfg();
        for (int a = 0; a < (1 << ADDR_W); a++) rom_mem[a] = 4'((a % 3) + 1);
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_pix", pix_index, 0);
        chk("reset_rom_addr", rom_bus.rom_addr, 0);
        Reset_n = 1'b1;

        // No line_start yet: nothing displayed anywhere
        for (int x = 0; x < int'(H_ACTIVE); x++) begin
            read_px(x, v);
            chk("idle_pix", v, 0);
            chk("idle_busy", busy, 0);
            chk("idle_overrun", overrun, 0);
        end

        // Single duck, ROM word = addr%3+1
        den[0] = 1; dx[0] = 100; dy[0] = 200;
        apply_cfg();
        wait_idle();
        pulse_line(210, 0);
        wait_fill(model_cycles(210), fa);
        chk("first_rom_addr", fa, 500);
        model_line(210);
        pulse_line(0, 0);
        sweep("single_duck");
        read_px(99, v);  chk("left_of_duck", v, 0);
        read_px(150, v); chk("right_of_duck", v, 0);
        read_px(100, v); chk("duck_col0", v, 4'((500 % 3) + 1));
        read_px(149, v); chk("duck_col49", v, 4'((549 % 3) + 1));

        // Priority and transparency: duck1 over duck0, hole at col 5
        rom_random(1);
        for (int c = 0; c < int'(SPRITE_W); c++) begin
            rom_mem[c]       = 4'd1;
            rom_mem[500 + c] = (c == 5) ? 4'd0 : 4'd2;
        end
        den[0] = 1; dx[0] = 100; dy[0] = 10;
        den[1] = 1; dx[1] = 100; dy[1] = 0;
        den[2] = 0;
        apply_cfg();
        do_line(10, "priority", fa);
        read_px(105, v); chk("transparent_hole", v, 1);
        read_px(106, v); chk("top_duck_wins", v, 2);

        // Right-edge clipping, no wrap to the left
        rom_random(0);
        den[0] = 0; den[1] = 0;
        den[2] = 1; dx[2] = 620; dy[2] = 0;
        apply_cfg();
        do_line(5, "clip", fa);
        read_px(0, v);   chk("no_wrap_x0", v, 0);
        read_px(29, v);  chk("no_wrap_x29", v, 0);
        read_px(620, v); chk("clip_first", v, rom_mem[250]);
        read_px(639, v); chk("clip_last", v, rom_mem[269]);

        // Overrun mid-clear: one-cycle pulse, restart from scratch, banks still swap
        rom_random(0);
        den[0] = 1; dx[0] = 100; dy[0] = 0;
        den[1] = 0; den[2] = 0;
        apply_cfg();
        wait_idle();
        pulse_line(0, 0);
        wait_fill(model_cycles(0), fa);
        pulse_line(7, 0);
        repeat (299) step();
        pulse_line(9, 1);
        wait_fill(model_cycles(9), fa);
        read_px(120, v); chk("partial_bank_shown", v, 0);
        model_line(9);
        pulse_line(0, 0);
        sweep("after_overrun");

        // Reset in the middle of a fetch, then a full three-duck fill
        rom_random(1);
        den[0] = 1; dx[0] = 0;   dy[0] = 280;
        den[1] = 1; dx[1] = 200; dy[1] = 300;
        den[2] = 1; dx[2] = 600; dy[2] = 251;
        apply_cfg();
        wait_idle();
        pulse_line(300, 0);
        repeat (660) step();
        Reset_n = 1'b0;
        step();
        chk("midfetch_reset_busy", busy, 0);
        chk("midfetch_reset_pix", pix_index, 0);
        chk("midfetch_reset_overrun", overrun, 0);
        Reset_n = 1'b1;
        step();
        chk("post_reset_busy", busy, 0);
        chk("post_reset_pix", pix_index, 0);
        pulse_line(300, 0);
        wait_fill(FULL_FILL, fa);
        model_line(300);
        pulse_line(0, 0);
        sweep("three_ducks");

        // Randomized scenes
        for (int it = 0; it < 6; it++) begin
            rom_random(1);
            y = $urandom_range(0, 700);
            for (int d = 0; d < NUM_DUCKS; d++) begin
                den[d] = ($urandom_range(0, 3) != 0);
                dx[d]  = $urandom_range(0, 700);
                dy[d]  = y - int'($urandom_range(0, 70));
                if (dy[d] < 0) dy[d] = 0;
            end
            apply_cfg();
            do_line(y, "random_scene", fa);
        end

        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
